robocup_spi_cmd_slave: RTL and testbench
========================================

// Module: robocup_spi_cmd_slave
// PURPOSE
//  Responder end of the MCU->FPGA SPI command link (mode 0, MSB first, byte frames).
//  Oversamples SCK/MOSI/NCS in the sysclk domain and decodes the command byte.
//  Commits motor duty cycles, hall count writes and motor enables to the motor cores.
//  Shifts encoder counts, hall counts, duty cycles and status back on MISO.
// PARAMETERS
//  NUM_MOTORS   5   motor channels; the frame length scales with this value
//  DUTY_WIDTH   11  duty bits per motor, sent as lo byte then hi byte (hi byte bits [DUTY_WIDTH-9:0] used)
//  ENC_WIDTH    16  encoder count bits per motor, returned lo byte then hi byte
// PORTS
//  sysclk          in   1                 single clock for the whole block
//  rst             in   1                 synchronous, active-high reset
//  spi_slave_sck   in   1                 SPI clock, asynchronous, CPOL=0
//  spi_slave_mosi  in   1                 master data out
//  spi_slave_ncs   in   1                 active-low frame select
//  spi_slave_miso  out  1                 slave data; drives 0 when NCS is high
//  enc_count       in   NUM_MOTORS*16     live encoder counts, motor 0 in the LSBs
//  hall_count      in   NUM_MOTORS*8      live hall counts
//  duty_cycle      out  NUM_MOTORS*11     committed duty cycles
//  duty_strobe     out  1                 1-cycle pulse when duty_cycle updates
//  hall_cnt_wr     out  NUM_MOTORS        1-cycle write strobes, one per motor, all high together
//  hall_cnt_wdata  out  NUM_MOTORS*8      hall preset data, valid while hall_cnt_wr is high
//  motors_en       out  1                 global motor enable
// BEHAVIOUR
//  - Reset: duty_cycle=0, motors_en=0, miso=0, all strobes=0, FSM=IDLE, shift and counter regs=0.
//  - Sync: 2-flop synchronizers, then edge detect on SCK.
//    SCK high and low phases are each >=4 sysclk; this is the supported SCK rate.
//    MOSI is sampled on the detected SCK rise; MISO changes on the detected fall.
//    Bit 7 of the first byte is driven within 3 cycles of NCS falling.
//  - FSM states: IDLE -> CMD (NCS low) -> DATA (8th rise of byte 0) -> COMMIT (NCS rise) -> IDLE.
//    From CMD, an NCS rise returns to IDLE with no commit.
//  - Command byte fields: bit7=R/EN flag, bits[6:0]=opcode. During byte 0 MISO returns status {motors_en,7'h00}.
//    0x00/0x80: write duty cycles, 2*NUM_MOTORS data bytes. With bit7 set, MISO returns the enc_count snapshot.
//    0x12: write hall counts, NUM_MOTORS data bytes. MISO returns 0x00.
//    0x92: read hall counts, one byte per motor.
//    0x93: read duty cycles, 2*NUM_MOTORS bytes (lo, hi zero-extended).
//    0x30/0xB0: motors_en <= bit7. Takes effect at COMMIT and needs no data bytes.
//    Any other opcode: data ignored, MISO 0x00, no commit.
//  - Snapshot: read data is latched on the cycle the command byte completes, so multi-byte reads are coherent.
//    The next TX byte is loaded after each byte's 8th fall.
//  - Writes go to shadow regs. COMMIT applies them only if exactly the required byte count was received
//    (incomplete frame = discard).
//  - Extra bytes past the required count: ignored, MISO 0x00, frame still commits.
//  - A partial byte (NCS rise with bit count !=0) voids the write commit. Read-only frames are unaffected.
//  - duty_strobe and hall_cnt_wr pulse exactly 1 cycle, in the cycle after NCS rise is detected.
//  - rst asserted mid-frame: everything returns to reset values. The rest of that frame is ignored until NCS goes high.
// CONFIGURATION
//  ROBOCUP_SPI_ERR_CNT_EN
//    Defined: 8-bit saturating err_count (stops at 0xFF) increments on each discarded or unknown-opcode frame.
//    Opcode 0x94 returns err_count in 1 byte and clears it at COMMIT.
//    Undefined: no counter is built, and 0x94 is treated as an unknown opcode.
// TESTING
//  - Reset with NCS=1 -> miso=0, motors_en=0, duty_cycle=0, no strobes.
//  - Write frame 80 EC 03 BD 01 E3 01 4B 01 F6 02 with enc_count[0]=0x1234
//    -> MISO shows bytes 00,34,12 at positions 0-2.
//    -> duty = {0x3EC,0x1BD,0x1E3,0x14B,0x2F6}, one duty_strobe pulse.
//  - 12 08 0A 02 05 03 -> one hall_cnt_wr=5'b11111 pulse with wdata {03,05,02,0A,08}.
//    Then 92 + 5 dummy bytes -> MISO bytes 08 0A 02 05 03 when hall_count is looped back.
//  - B0 -> motors_en=1 and status byte reads 0x80. 30 -> motors_en=0.
//    93 + 10 dummy bytes -> MISO returns the committed duties, lo then hi.
//  - 80 EC 03 then NCS high (incomplete frame) -> duty unchanged, no strobe, err_count=1 when the macro is defined.
//  - Assert rst mid-frame during 0x80 byte 4 -> outputs reset; the next full frame decodes normally.

Source files
------------

// File: rtl/robocup_spi_cmd_slave_if.sv
// SPI command link pins between the MCU (master) and the FPGA responder (slave).
interface robocup_spi_cmd_slave_if;
    logic spi_slave_sck;
    logic spi_slave_mosi;
    logic spi_slave_ncs;
    logic spi_slave_miso;

    modport master (output spi_slave_sck, output spi_slave_mosi, output spi_slave_ncs, input spi_slave_miso);
    modport slave  (input spi_slave_sck, input spi_slave_mosi, input spi_slave_ncs, output spi_slave_miso);
endinterface

// File: rtl/robocup_spi_cmd_slave.sv
// SPI mode-0 command responder: oversampled pins, command decode, shadowed writes committed on NCS rise.
// Strobes land the cycle after NCS rise is seen; no backpressure. Optional ROBOCUP_SPI_ERR_CNT_EN adds err_count.
module robocup_spi_cmd_slave #(
    parameter int NUM_MOTORS = 5,
    parameter int DUTY_WIDTH = 11,
    parameter int ENC_WIDTH  = 16
) (
    input  logic                             sysclk,
    input  logic                             rst,
    robocup_spi_cmd_slave_if.slave           spi,
    input  logic [NUM_MOTORS*ENC_WIDTH-1:0]  enc_count,
    input  logic [NUM_MOTORS*8-1:0]          hall_count,
    output logic [NUM_MOTORS*DUTY_WIDTH-1:0] duty_cycle,
    output logic                             duty_strobe,
    output logic [NUM_MOTORS-1:0]            hall_cnt_wr,
    output logic [NUM_MOTORS*8-1:0]          hall_cnt_wdata,
    output logic                             motors_en
`ifdef ROBOCUP_SPI_ERR_CNT_EN
    ,
    output logic [7:0]                       err_count
`endif
);
    localparam int NBYTES = 2 * NUM_MOTORS;
    localparam int IW = $clog2(NBYTES);
    localparam logic [7:0] NB_DUTY = 8'(NBYTES);
    localparam logic [7:0] NB_HALL = 8'(NUM_MOTORS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;
    state_t state_q, state_d;

    logic [1:0] sck_s, mosi_s, ncs_s;
    logic       sck_d, ncs_d;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt, rx_shift, tx_shift, cmd_q, rx_byte, next_tx;
    logic [7:0] snap_q [NBYTES];
    logic [7:0] snap_d [NBYTES];
    logic [7:0] data_buf [NBYTES];
    logic sck_rise, sck_fall, ncs_fall, ncs_rise, in_frame, byte_done;
    logic is_duty, is_hall_wr, is_en, is_rd, write_ok, commit, do_duty, do_hall, do_en;

    // ncs_d resets low so a frame already in progress at reset is never picked up mid-way
    assign sck_rise  = sck_s[1] & ~sck_d;
    assign sck_fall  = ~sck_s[1] & sck_d;
    assign ncs_fall  = ~ncs_s[1] & ncs_d;
    assign ncs_rise  = ncs_s[1] & ~ncs_d;
    assign in_frame  = (state_q == CMD) || (state_q == DATA);
    assign rx_byte   = {rx_shift[6:0], mosi_s[1]};
    assign byte_done = in_frame & sck_rise & (bit_cnt == 3'd7);
    assign next_tx   = (byte_cnt < NB_DUTY) ? snap_q[byte_cnt[IW-1:0]] : 8'h00;
    assign spi.spi_slave_miso = in_frame ? tx_shift[7] : 1'b0;

    assign is_duty    = (cmd_q[6:0] == 7'h00);
    assign is_hall_wr = (cmd_q == 8'h12);
    assign is_en      = (cmd_q[6:0] == 7'h30);
`ifdef ROBOCUP_SPI_ERR_CNT_EN
    assign is_rd      = (cmd_q == 8'h92) || (cmd_q == 8'h93) || (cmd_q == 8'h94);
`else
    assign is_rd      = (cmd_q == 8'h92) || (cmd_q == 8'h93);
`endif
    assign write_ok = (bit_cnt == 3'd0);
    assign commit   = (state_q == DATA) & ncs_rise;
    assign do_duty  = commit & is_duty & write_ok & (byte_cnt >= NB_DUTY);
    assign do_hall  = commit & is_hall_wr & write_ok & (byte_cnt >= NB_HALL);
    assign do_en    = commit & is_en & write_ok;

    always_comb begin
        for (int i = 0; i < NBYTES; i++) snap_d[i] = 8'h00;
        case (rx_byte)
            8'h80: for (int i = 0; i < NUM_MOTORS; i++) begin
                snap_d[2*i]   = enc_count[i*ENC_WIDTH +: 8];
                snap_d[2*i+1] = enc_count[i*ENC_WIDTH+8 +: 8];
            end
            8'h92: for (int i = 0; i < NUM_MOTORS; i++) snap_d[i] = hall_count[i*8 +: 8];
            8'h93: for (int i = 0; i < NUM_MOTORS; i++) begin
                snap_d[2*i]   = duty_cycle[i*DUTY_WIDTH +: 8];
                snap_d[2*i+1] = 8'(duty_cycle[i*DUTY_WIDTH+8 +: DUTY_WIDTH-8]);
            end
`ifdef ROBOCUP_SPI_ERR_CNT_EN
            8'h94: snap_d[0] = err_count;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall) state_d = CMD;
            CMD:     if (ncs_rise) state_d = IDLE;
                     else if (byte_done) state_d = DATA;
            DATA:    if (ncs_rise) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sck_s <= '0; mosi_s <= '0; ncs_s <= '0; sck_d <= 1'b0; ncs_d <= 1'b0;
            bit_cnt <= '0; byte_cnt <= '0; rx_shift <= '0; tx_shift <= '0; cmd_q <= '0;
            duty_cycle <= '0; duty_strobe <= 1'b0; hall_cnt_wr <= '0; hall_cnt_wdata <= '0; motors_en <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                snap_q[i]   <= 8'h00;
                data_buf[i] <= 8'h00;
            end
        end else begin
            sck_s  <= {sck_s[0], spi.spi_slave_sck};
            mosi_s <= {mosi_s[0], spi.spi_slave_mosi};
            ncs_s  <= {ncs_s[0], spi.spi_slave_ncs};
            sck_d  <= sck_s[1];
            ncs_d  <= ncs_s[1];
            duty_strobe <= do_duty;
            hall_cnt_wr <= {NUM_MOTORS{do_hall}};
            if (do_duty)
                for (int i = 0; i < NUM_MOTORS; i++)
                    duty_cycle[i*DUTY_WIDTH +: DUTY_WIDTH] <= {data_buf[2*i+1][DUTY_WIDTH-9:0], data_buf[2*i]};
            if (do_hall)
                for (int i = 0; i < NUM_MOTORS; i++) hall_cnt_wdata[i*8 +: 8] <= data_buf[i];
            if (do_en) motors_en <= cmd_q[7];
            if (!in_frame) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                tx_shift <= {motors_en, 7'h00};
            end else begin
                if (sck_rise) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (state_q == CMD) begin
                        cmd_q  <= rx_byte;
                        snap_q <= snap_d;
                    end else begin
                        if (byte_cnt < NB_DUTY) data_buf[byte_cnt[IW-1:0]] <= rx_byte;
                        if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                // bit_cnt wraps to 0 on a byte's 8th rise, so the following fall starts the next TX byte
                if (sck_fall) tx_shift <= (bit_cnt == 3'd0) ? next_tx : {tx_shift[6:0], 1'b0};
            end
        end
    end

`ifdef ROBOCUP_SPI_ERR_CNT_EN
    logic discard;
    assign discard = commit & ~(do_duty | do_hall | do_en | is_rd);

    always_ff @(posedge sysclk) begin
        if (rst)                           err_count <= 8'h00;
        else if (commit && cmd_q == 8'h94) err_count <= 8'h00;
        else if (discard && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_robocup_spi_cmd_slave.sv
// Randomized frame-level bench for robocup_spi_cmd_slave against a byte-level reference model.
module tb_robocup_spi_cmd_slave;
    localparam int NM = 5;
    localparam int DW = 11;
    localparam int EW = 16;

    logic sysclk = 1'b0;
    logic rst = 1'b1;
    always #5 sysclk = ~sysclk;

    robocup_spi_cmd_slave_if spi_if ();
    logic [NM*EW-1:0] enc_count = '0;
    logic [NM*8-1:0]  hall_count = '0;
    logic [NM*DW-1:0] duty_cycle;
    logic             duty_strobe;
    logic [NM-1:0]    hall_cnt_wr;
    logic [NM*8-1:0]  hall_cnt_wdata;
    logic             motors_en;

    robocup_spi_cmd_slave #(.NUM_MOTORS(NM), .DUTY_WIDTH(DW), .ENC_WIDTH(EW)) dut (
        .sysclk(sysclk), .rst(rst), .spi(spi_if),
        .enc_count(enc_count), .hall_count(hall_count),
        .duty_cycle(duty_cycle), .duty_strobe(duty_strobe),
        .hall_cnt_wr(hall_cnt_wr), .hall_cnt_wdata(hall_cnt_wdata), .motors_en(motors_en)
    );

    int n_cmp = 0, n_bad = 0;
    int ds_cnt = 0, hw_cnt = 0;
    logic [NM*8-1:0] hw_last = '0;
    logic [NM-1:0]   hw_vec_last = '0;

    int         m_duty [NM];
    logic [7:0] m_hall [NM];
    logic       m_en;
    logic [7:0] dq [$];

    // strobe counters, plus hall counts looped back from the preset port
    always @(negedge sysclk) begin
        if (duty_strobe) ds_cnt <= ds_cnt + 1;
        if (|hall_cnt_wr) begin
            hw_cnt      <= hw_cnt + 1;
            hw_last     <= hall_cnt_wdata;
            hw_vec_last <= hall_cnt_wr;
            hall_count  <= hall_cnt_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge sysclk) spi_if.spi_slave_mosi = b[7-i];
            repeat (5) @(negedge sysclk);
            r[7-i] = spi_if.spi_slave_miso;
            spi_if.spi_slave_sck = 1'b1;
            repeat (5) @(negedge sysclk);
            spi_if.spi_slave_sck = 1'b0;
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] cmd, input int k);
        case (cmd)
            8'h80:   return (k < 2*NM) ? enc_count[(k/2)*EW + (k%2)*8 +: 8] : 8'h00;
            8'h92:   return (k < NM) ? m_hall[k] : 8'h00;
            8'h93:   return (k < 2*NM) ? ((k % 2 == 0) ? 8'(m_duty[k/2] & 255) : 8'(m_duty[k/2] >> 8)) : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        logic [NM*DW-1:0] ev;
        for (int i = 0; i < NM; i++) ev[i*DW +: DW] = DW'(m_duty[i]);
        chk({tag, ".duty"}, 64'(duty_cycle), 64'(ev));
        chk({tag, ".en"}, 64'(motors_en), 64'(m_en));
        chk({tag, ".miso_idle"}, 64'(spi_if.spi_slave_miso), 64'(0));
    endtask

    task automatic randomize_enc();
        for (int i = 0; i < NM; i++) enc_count[i*EW +: EW] = EW'($urandom);
    endtask

    task automatic frame(input logic [7:0] cmd, input int pbits, input string tag);
        logic [7:0] r, e, st;
        logic [NM*8-1:0] hv;
        int n, ds0, hw0, exp_ds, exp_hw;
        logic wr_ok;
        n = dq.size(); ds0 = ds_cnt; hw0 = hw_cnt;
        st = {m_en, 7'h00};
        spi_if.spi_slave_ncs = 1'b0;
        repeat (6) @(negedge sysclk);
        send_bits(cmd, 8, r);
        chk({tag, ".status"}, 64'(r), 64'(st));
        for (int k = 0; k < n; k++) begin
            e = exp_rx(cmd, k);
            send_bits(dq[k], 8, r);
            chk($sformatf("%s.rx%0d", tag, k), 64'(r), 64'(e));
        end
        if (pbits > 0) send_bits(8'($urandom), pbits, r);
        repeat (3) @(negedge sysclk);
        spi_if.spi_slave_ncs = 1'b1;
        repeat (10) @(negedge sysclk);

        wr_ok = (pbits == 0); exp_ds = 0; exp_hw = 0;
        if (cmd[6:0] == 7'h00 && wr_ok && n >= 2*NM) begin
            for (int i = 0; i < NM; i++) m_duty[i] = int'({dq[2*i+1][2:0], dq[2*i]});
            exp_ds = 1;
        end
        if (cmd == 8'h12 && wr_ok && n >= NM) begin
            for (int i = 0; i < NM; i++) m_hall[i] = dq[i];
            exp_hw = 1;
        end
        if (cmd[6:0] == 7'h30 && wr_ok) m_en = cmd[7];

        chk({tag, ".duty_strobes"}, 64'(ds_cnt - ds0), 64'(exp_ds));
        chk({tag, ".hall_wr_cycles"}, 64'(hw_cnt - hw0), 64'(exp_hw));
        if (exp_hw == 1) begin
            for (int i = 0; i < NM; i++) hv[i*8 +: 8] = m_hall[i];
            chk({tag, ".hall_wdata"}, 64'(hw_last), 64'(hv));
            chk({tag, ".hall_wr_vec"}, 64'(hw_vec_last), 64'({NM{1'b1}}));
        end
        check_outputs(tag);
    endtask

    task automatic fill(input int n);
        dq.delete();
        for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] r, op;
        int sel, ds0;
        spi_if.spi_slave_ncs = 1'b1;
        spi_if.spi_slave_sck = 1'b0;
        spi_if.spi_slave_mosi = 1'b0;
        for (int i = 0; i < NM; i++) begin m_duty[i] = 0; m_hall[i] = 8'h00; end
        m_en = 1'b0;

        rst = 1'b1;
        repeat (5) @(negedge sysclk);
        chk("reset.miso", 64'(spi_if.spi_slave_miso), 64'(0));
        chk("reset.en", 64'(motors_en), 64'(0));
        chk("reset.duty", 64'(duty_cycle), 64'(0));
        chk("reset.duty_strobe", 64'(duty_strobe), 64'(0));
        chk("reset.hall_wr", 64'(hall_cnt_wr), 64'(0));
        rst = 1'b0;
        repeat (5) @(negedge sysclk);

        randomize_enc();
        enc_count[EW-1:0] = 16'h1234;
        dq = '{8'hEC, 8'h03, 8'hBD, 8'h01, 8'hE3, 8'h01, 8'h4B, 8'h01, 8'hF6, 8'h02};
        frame(8'h80, 0, "duty_wr");
        dq = '{8'h08, 8'h0A, 8'h02, 8'h05, 8'h03};
        frame(8'h12, 0, "hall_wr");
        fill(5);
        frame(8'h92, 0, "hall_rd");
        dq.delete();
        frame(8'hB0, 0, "en_on");
        fill(10);
        frame(8'h93, 0, "duty_rd");
        dq.delete();
        frame(8'h30, 0, "en_off");
        dq = '{8'hEC, 8'h03};
        frame(8'h80, 0, "incomplete");
        fill(10);
        frame(8'h00, 3, "partial");
        fill(12);
        frame(8'h80, 0, "extra");
        fill(5);
        frame(8'h92, 4, "rd_partial");

        // reset in the middle of a duty write, partway through byte 4
        dq.delete();
        frame(8'hB0, 0, "en_pre_rst");
        ds0 = ds_cnt;
        spi_if.spi_slave_ncs = 1'b0;
        repeat (6) @(negedge sysclk);
        send_bits(8'h80, 8, r);
        for (int k = 0; k < 3; k++) send_bits(8'($urandom), 8, r);
        send_bits(8'($urandom), 4, r);
        @(negedge sysclk) rst = 1'b1;
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < NM; i++) m_duty[i] = 0;
        m_en = 1'b0;
        check_outputs("rst_mid");
        chk("rst_mid.duty_strobe", 64'(duty_strobe), 64'(0));
        rst = 1'b0;
        send_bits(8'($urandom), 4, r);
        for (int k = 0; k < 6; k++) send_bits(8'($urandom), 8, r);
        repeat (3) @(negedge sysclk);
        spi_if.spi_slave_ncs = 1'b1;
        repeat (10) @(negedge sysclk);
        chk("rst_mid.no_strobe", 64'(ds_cnt - ds0), 64'(0));
        check_outputs("rst_after");
        randomize_enc();
        fill(10);
        frame(8'h80, 0, "post_rst_wr");

        for (int t = 0; t < 25; t++) begin
            randomize_enc();
            sel = $urandom_range(0, 7);
            case (sel)
                0: begin fill(10 + $urandom_range(0, 2)); frame(($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00, 0, $sformatf("r%0d.duty_wr", t)); end
                1: begin fill(5 + $urandom_range(0, 1)); frame(8'h12, 0, $sformatf("r%0d.hall_wr", t)); end
                2: begin fill(5 + $urandom_range(0, 1)); frame(8'h92, 0, $sformatf("r%0d.hall_rd", t)); end
                3: begin fill(10); frame(8'h93, 0, $sformatf("r%0d.duty_rd", t)); end
                4: begin dq.delete(); frame(($urandom_range(0, 1) == 1) ? 8'hB0 : 8'h30, 0, $sformatf("r%0d.en", t)); end
                5: begin
                    do op = 8'($urandom);
                    while (op[6:0] == 7'h00 || op == 8'h12 || op == 8'h92 || op == 8'h93 || op[6:0] == 7'h30 || op == 8'h94);
                    fill($urandom_range(0, 3));
                    frame(op, 0, $sformatf("r%0d.unknown", t));
                end
                6: begin fill($urandom_range(0, 9)); frame(8'h80, 0, $sformatf("r%0d.short", t)); end
                default: begin fill(10); frame(8'h80, $urandom_range(1, 7), $sformatf("r%0d.partial", t)); end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
